// File: rtl/gen_sequencer_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer: field size
// defaults, neighbour count, FSM state type and the per-cell life rule.
package gen_sequencer_pkg;

    localparam int unsigned NEIGHBOURS_CNT = 8;
    localparam int unsigned NB_CNT_W       = 4;
    localparam int unsigned FIELD_W_DEF    = 32;
    localparam int unsigned FIELD_H_DEF    = 24;
    localparam int unsigned GEN_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DONE
    } gen_seq_state_t;

    // Survive on 2 or 3 live neighbours, birth on exactly 3.
    function automatic logic cell_rule(input logic alive, input logic [NB_CNT_W-1:0] cnt);
        return (cnt == NB_CNT_W'(3)) || (alive && (cnt == NB_CNT_W'(2)));
    endfunction

endpackage

// File: rtl/gen_sequencer_if.sv
// Control and row-memory bus of the generation sequencer.
// master: sequencer side (drives o_*, samples i_*); slave: controller/RAM side.
interface gen_sequencer_if
    import gen_sequencer_pkg::*;
#(
    parameter int unsigned FIELD_W   = FIELD_W_DEF,
    parameter int unsigned FIELD_H   = FIELD_H_DEF,
    parameter int unsigned GEN_CNT_W = GEN_CNT_W_DEF
) ();

    localparam int unsigned ROW_AW = $clog2(FIELD_H);

    logic                 i_start;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_bank;
    logic                 o_rd_en;
    logic [ROW_AW-1:0]    o_rd_addr;
    logic [FIELD_W-1:0]   i_rd_data;
    logic                 o_wr_en;
    logic [ROW_AW-1:0]    o_wr_addr;
    logic [FIELD_W-1:0]   o_wr_data;
    logic [GEN_CNT_W-1:0] o_gen_cnt;

    modport master (
        input  i_start, i_rd_data,
        output o_busy, o_done, o_bank, o_rd_en, o_rd_addr,
               o_wr_en, o_wr_addr, o_wr_data, o_gen_cnt
    );

    modport slave (
        output i_start, i_rd_data,
        input  o_busy, o_done, o_bank, o_rd_en, o_rd_addr,
               o_wr_en, o_wr_addr, o_wr_data, o_gen_cnt
    );

endinterface

// File: rtl/gen_sequencer_next_row.sv
// Row-wide next-generation evaluator.
//   next_cell_state: alive_i + 8 neighbour bits -> next_o (life rule).
//   next_row_state : top_i/mid_i/bot_i rows -> next_o row, columns wrap
//                    horizontally (column 0 neighbours column FIELD_W-1).
module next_cell_state
    import gen_sequencer_pkg::*;
(
    input  logic                      alive_i,
    input  logic [NEIGHBOURS_CNT-1:0] nbrs_i,
    output logic                      next_o
);

    logic [NB_CNT_W-1:0] cnt;

    // Population count of the neighbourhood.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
            cnt = cnt + NB_CNT_W'(nbrs_i[i]);
        end
        next_o = cell_rule(alive_i, cnt);
    end

endmodule

module next_row_state
    import gen_sequencer_pkg::*;
#(
    parameter int unsigned FIELD_W = FIELD_W_DEF
) (
    input  logic [FIELD_W-1:0] top_i,
    input  logic [FIELD_W-1:0] mid_i,
    input  logic [FIELD_W-1:0] bot_i,
    output logic [FIELD_W-1:0] next_o
);

    for (genvar c = 0; c < FIELD_W; c++) begin : g_col
        localparam int unsigned L = (c + FIELD_W - 1) % FIELD_W;
        localparam int unsigned R = (c + 1) % FIELD_W;

        next_cell_state u_cell (
            .alive_i (mid_i[c]),
            .nbrs_i  ({top_i[L], top_i[c], top_i[R],
                       mid_i[L],           mid_i[R],
                       bot_i[L], bot_i[c], bot_i[R]}),
            .next_o  (next_o[c])
        );
    end

endmodule

// File: rtl/gen_sequencer.sv
// Sequences one Game-of-Life generation over a double-buffered row memory.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : i_start request, o_busy/o_done status, o_bank read bank,
//                  row read port (o_rd_en/o_rd_addr -> i_rd_data one cycle later),
//                  row write port into bank ~o_bank, o_gen_cnt generation count.
module gen_sequencer
    import gen_sequencer_pkg::*;
#(
    parameter int unsigned FIELD_W   = FIELD_W_DEF,
    parameter int unsigned FIELD_H   = FIELD_H_DEF,
    parameter int unsigned GEN_CNT_W = GEN_CNT_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    gen_sequencer_if.master bus
);

    localparam int unsigned ROW_AW = $clog2(FIELD_H);
    localparam int unsigned AW1    = ROW_AW + 1;
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(FIELD_H - 1);
    localparam logic [ROW_AW-1:0] PENU_ROW = ROW_AW'(FIELD_H - 2);

    if (FIELD_H < 3 || FIELD_W < 3) begin : g_bad_geometry
        $error("gen_sequencer: FIELD_H and FIELD_W must both be at least 3");
    end

    gen_seq_state_t       state_q;
    logic [1:0]           phase_q;
    logic [ROW_AW-1:0]    k_q;
    logic [FIELD_W-1:0]   top_q;
    logic [FIELD_W-1:0]   mid_q;
    logic                 bank_q;
    logic [GEN_CNT_W-1:0] gen_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_en_q;
    logic [ROW_AW-1:0]    rd_addr_q;
    logic                 wr_en_q;

    logic [FIELD_W-1:0]   next_row;
    logic [AW1-1:0]       k_plus3;
    logic [ROW_AW-1:0]    rd_ahead;

    // Row fetched during row k+1 is (k+3) mod H, landing as bot for row k+2.
    assign k_plus3  = {1'b0, k_q} + AW1'(3);
    assign rd_ahead = (k_plus3 >= AW1'(FIELD_H)) ? ROW_AW'(k_plus3 - AW1'(FIELD_H))
                                                  : ROW_AW'(k_plus3);

    next_row_state #(.FIELD_W(FIELD_W)) u_next_row (
        .top_i  (top_q),
        .mid_i  (mid_q),
        .bot_i  (bus.i_rd_data),
        .next_o (next_row)
    );

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_bank    = bank_q;
    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = k_q;
    // Gated so the write data bus stays quiet outside RUN.
    assign bus.o_wr_data = wr_en_q ? next_row : '0;
    assign bus.o_gen_cnt = gen_cnt_q;

    // FSM, window, counters; outputs are set one cycle ahead of their use.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            k_q       <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bank_q    <= 1'b0;
            gen_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        state_q   <= PRIME;
                        phase_q   <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= LAST_ROW;
                    end
                end
                PRIME: begin
                    phase_q <= phase_q + 2'd1;
                    rd_en_q <= 1'b1;
                    case (phase_q)
                        2'd0: rd_addr_q <= ROW_AW'(0);
                        2'd1: begin
                            rd_addr_q <= ROW_AW'(1);
                            mid_q     <= bus.i_rd_data;
                        end
                        default: begin
                            rd_addr_q <= ROW_AW'(2);
                            top_q     <= mid_q;
                            mid_q     <= bus.i_rd_data;
                            state_q   <= RUN;
                            wr_en_q   <= 1'b1;
                            k_q       <= '0;
                        end
                    endcase
                end
                RUN: begin
                    top_q <= mid_q;
                    mid_q <= bus.i_rd_data;
                    if (k_q == LAST_ROW) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        wr_en_q <= 1'b0;
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + ROW_AW'(1);
                        // Row H-1 is evaluated with the last fetch already in flight.
                        if (k_q != PENU_ROW) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_ahead;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    bank_q    <= ~bank_q;
                    gen_cnt_q <= gen_cnt_q + GEN_CNT_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_sequencer.sv
// Bench for gen_sequencer: behavioural 2-bank row RAM, torus life model,
// expected read/write/done transactions queued per generation and checked
// by an independent monitor on the falling edge.
module tb_gen_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned CW = 2;

    typedef logic [W-1:0] row_t;
    typedef row_t field_t [H];
    typedef struct { int addr; row_t data; } wr_exp_t;
    typedef struct { logic bank; int cnt; } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gen_sequencer_if #(.FIELD_W(W), .FIELD_H(H), .GEN_CNT_W(CW)) bus ();

    gen_sequencer #(.FIELD_W(W), .FIELD_H(H), .GEN_CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Row RAM: reads from o_bank with one-cycle latency, writes to ~o_bank.
    row_t   mem [2][H];
    logic   ld_req = 1'b0;
    field_t ld_field;
    always @(posedge clk) begin
        if (ld_req) for (int r = 0; r < H; r++) mem[0][r] <= ld_field[r];
        if (bus.o_wr_en) mem[~bus.o_bank][bus.o_wr_addr] <= bus.o_wr_data;
        if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_bank][bus.o_rd_addr];
    end

    wr_exp_t   wq [$];
    int        rq [$];
    done_exp_t dq [$];
    int        checks = 0;
    int        errors = 0;
    int        dones_seen = 0;
    bit        mon_en = 1'b0;

    field_t cur;
    logic   exp_bank;
    int     exp_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: pop and compare whenever the DUT presents a transaction.
    always @(negedge clk) begin : monitor
        wr_exp_t   e;
        done_exp_t d;
        if (mon_en) begin
            if (bus.o_rd_en) begin
                if (rq.size() == 0) fail_now("rd_unexpected");
                else chk("rd_addr", int'(bus.o_rd_addr), rq.pop_front());
            end
            if (bus.o_wr_en) begin
                if (wq.size() == 0) fail_now("wr_unexpected");
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", int'(bus.o_wr_addr), e.addr);
                    chk("wr_data", int'(bus.o_wr_data), int'(e.data));
                    chk("wr_busy", int'(bus.o_busy), 1);
                end
            end
            if (bus.o_done) begin
                dones_seen++;
                if (dq.size() == 0) fail_now("done_unexpected");
                else begin
                    d = dq.pop_front();
                    chk("done_bank", int'(bus.o_bank), int'(d.bank));
                    chk("done_cnt", int'(bus.o_gen_cnt), d.cnt);
                end
            end
            if (!bus.o_busy)
                chk("idle_quiet", int'({bus.o_rd_en, bus.o_wr_en, bus.o_done, |bus.o_wr_data}), 0);
        end
    end

    // Reference: one life step on the H x W torus.
    function automatic void life_step(input field_t f, output field_t n);
        int cnt;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        if (!(dr == 1 && dc == 1))
                            cnt += int'(f[(r + dr + H - 1) % H][(c + dc + W - 1) % W]);
                n[r][c] = (cnt == 3) || (f[r][c] && cnt == 2);
            end
        end
    endfunction

    function automatic void glider(input int r0, input int c0, output field_t f);
        for (int r = 0; r < H; r++) f[r] = '0;
        f[(r0 + 0) % H][(c0 + 1) % W] = 1'b1;
        f[(r0 + 1) % H][(c0 + 2) % W] = 1'b1;
        f[(r0 + 2) % H][(c0 + 0) % W] = 1'b1;
        f[(r0 + 2) % H][(c0 + 1) % W] = 1'b1;
        f[(r0 + 2) % H][(c0 + 2) % W] = 1'b1;
    endfunction

    // Queue everything one generation from field f must produce.
    task automatic expect_gen(input field_t f, output field_t n);
        done_exp_t d;
        life_step(f, n);
        rq.push_back(H - 1);
        for (int r = 0; r < H; r++) rq.push_back(r);
        rq.push_back(0);
        for (int r = 0; r < H; r++) wq.push_back('{r, n[r]});
        d.bank = exp_bank;
        d.cnt  = exp_cnt;
        dq.push_back(d);
        exp_bank = ~exp_bank;
        exp_cnt  = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic flush();
        wq.delete();
        rq.delete();
        dq.delete();
        exp_bank = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        flush();
    endtask

    task automatic load(input field_t f);
        @(negedge clk);
        ld_field = f;
        ld_req   = 1'b1;
        @(negedge clk) ld_req = 1'b0;
        cur = f;
    endtask

    task automatic chk_bank(input string nm, input logic b, input field_t f);
        for (int r = 0; r < H; r++) chk(nm, int'(mem[b][r]), int'(f[r]));
    endtask

    // One generation; pulse_at[j] drives i_start in cycle j, rst_at>0 resets then.
    task automatic run_one(input logic [63:0] pulse_at, input int rst_at);
        field_t n;
        int     done_cyc;
        bit     finished;
        expect_gen(cur, n);
        @(negedge clk) bus.i_start = 1'b1;
        done_cyc = -1;
        finished = 1'b0;
        for (int j = 1; j < 64 && !finished; j++) begin
            @(negedge clk);
            if (rst_at > 0 && j == rst_at + 1) begin
                rst = 1'b0;
                chk("rst_busy", int'(bus.o_busy), 0);
                chk("rst_bank", int'(bus.o_bank), 0);
                chk("rst_cnt", int'(bus.o_gen_cnt), 0);
                chk("rst_done", int'(bus.o_done), 0);
                flush();
                finished = 1'b1;
            end else if (done_cyc >= 0 && j == done_cyc + 1) begin
                bus.i_start = 1'b0;
                chk("post_bank", int'(bus.o_bank), int'(exp_bank));
                chk("post_cnt", int'(bus.o_gen_cnt), exp_cnt);
                chk("post_busy", int'(bus.o_busy), 0);
                chk("done_cycle", done_cyc, H + 4);
                chk_bank("ram_gen", exp_bank, n);
                cur = n;
                finished = 1'b1;
            end else begin
                if (bus.o_done && done_cyc < 0) done_cyc = j;
                bus.i_start = pulse_at[j];
                if (j == rst_at) begin
                    rst = 1'b1;
                    bus.i_start = 1'b0;
                end
            end
        end
        if (!finished) begin
            bus.i_start = 1'b0;
            fail_now("done_timeout");
        end
    endtask

    // n generations with i_start held high throughout.
    task automatic run_b2b(input int n);
        field_t f;
        field_t nx;
        logic   bank_seq [8];
        int     cnt_seq [8];
        int     got;
        int     prev;
        f = cur;
        for (int g = 0; g < n; g++) begin
            expect_gen(f, nx);
            f = nx;
            bank_seq[g] = exp_bank;
            cnt_seq[g]  = exp_cnt;
        end
        got  = 0;
        prev = -1;
        @(negedge clk) bus.i_start = 1'b1;
        for (int j = 1; j < n * (H + 5) + 20; j++) begin
            @(negedge clk);
            if (prev >= 0 && j == prev + 1) begin
                chk("b2b_bank", int'(bus.o_bank), int'(bank_seq[got - 1]));
                chk("b2b_cnt", int'(bus.o_gen_cnt), cnt_seq[got - 1]);
                if (got == n) begin
                    bus.i_start = 1'b0;
                    break;
                end
            end
            if (bus.o_done) begin
                if (prev >= 0) chk("done_spacing", j - prev, H + 5);
                else chk("first_done", j, H + 4);
                prev = j;
                got++;
            end
        end
        bus.i_start = 1'b0;
        chk("b2b_dones", got, n);
        cur = f;
        chk_bank("ram_b2b", exp_bank, f);
    endtask

    initial begin : main
        field_t f;
        field_t g;
        int     d0;
        bus.i_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_bank", int'(bus.o_bank), 0);
        chk("reset_cnt", int'(bus.o_gen_cnt), 0);
        chk("reset_busy", int'(bus.o_busy), 0);
        chk("reset_done", int'(bus.o_done), 0);
        chk("reset_rd_en", int'(bus.o_rd_en), 0);
        chk("reset_wr_en", int'(bus.o_wr_en), 0);
        chk("reset_rd_addr", int'(bus.o_rd_addr), 0);
        chk("reset_wr_addr", int'(bus.o_wr_addr), 0);
        chk("reset_wr_data", int'(bus.o_wr_data), 0);
        rst = 1'b0;
        flush();
        mon_en = 1'b1;

        // Block still-life, 5 back-to-back generations (counter wraps at 2 bits).
        for (int r = 0; r < H; r++) f[r] = '0;
        f[2] = 8'b0001_1000;
        f[3] = 8'b0001_1000;
        load(f);
        run_b2b(5);
        chk_bank("block_still", exp_bank, f);

        // Blinker: two generations return to the start pattern.
        do_reset();
        for (int r = 0; r < H; r++) f[r] = '0;
        f[2] = 8'b0001_1100;
        load(f);
        run_one('0, 0);
        for (int r = 0; r < H; r++)
            chk("blinker_g1", int'(mem[1][r]), (r >= 1 && r <= 3) ? 8 : 0);
        run_one('0, 0);
        chk_bank("blinker_g2", 1'b0, f);

        // Glider across both wrap seams moves by (+1,+1) in 4 generations.
        do_reset();
        glider(4, 6, f);
        load(f);
        repeat (4) run_one('0, 0);
        glider(5, 7, g);
        chk_bank("glider_shift", exp_bank, g);

        // i_start pulses in PRIME, RUN and DONE are ignored.
        d0 = dones_seen;
        run_one(64'h444, 0);
        repeat (20) @(negedge clk);
        chk("ignored_starts", dones_seen - d0, 1);

        // Reset at k=3, then a normal generation.
        do_reset();
        for (int r = 0; r < H; r++) f[r] = row_t'($urandom);
        load(f);
        d0 = dones_seen;
        run_one('0, 7);
        repeat (15) @(negedge clk);
        chk("reset_no_done", dones_seen - d0, 0);
        run_one('0, 0);

        // Random fields, random ignored pulses and idle gaps.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int r = 0; r < H; r++) f[r] = row_t'($urandom);
            load(f);
            for (int k = 0; k < 3; k++) begin
                run_one({$urandom, $urandom} & 64'h7FE, 0);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", wq.size() + rq.size() + dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_sequencer.md
# gen_sequencer

Sequences one Game-of-Life generation over a double-buffered, row-organised field memory. It sweeps the current bank row by row and keeps a three-row sliding window. Each window feeds a row-wide array of per-cell next-state evaluators, and each result row is written to the other bank. It sits between the top-level step/run control and the field RAM, and flips the active bank when a generation completes.

## Interface
- FIELD_W, 32, cells per row (row memory word width); ≥3
- FIELD_H, 24, rows in field; ≥3 (static assert)
- ROW_AW, $clog2(FIELD_H), row address width
- GEN_CNT_W, 16, generation counter width
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  request one generation; sampled only in IDLE
- o_busy  out  1  high PRIME..DONE inclusive
- o_done  out  1  one-cycle pulse in DONE
- o_bank  out  1  current (read) bank; writes go to ~o_bank
- o_rd_en  out  1  row read strobe, source bank o_bank
- o_rd_addr  out  ROW_AW  row to read
- i_rd_data  in  FIELD_W  row data, valid exactly one cycle after o_rd_en
- o_wr_en  out  1  row write strobe, destination bank ~o_bank
- o_wr_addr  out  ROW_AW  row to write
- o_wr_data  out  FIELD_W  next-generation row
- o_gen_cnt  out  GEN_CNT_W  completed generations, wraps modulo 2^GEN_CNT_W

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE → PRIME when i_start=1. i_start is ignored in every other state (no queuing).
- PRIME: 3 cycles, phases p=0..2. Phase p reads rows H-1, 0, 1.
  - End of p=1: mid ← i_rd_data (row H-1).
  - End of p=2: top ← mid, mid ← i_rd_data (row 0).
- RUN: row counter k=0..H-1.
  - Window: top = row k-1 mod H, mid = row k, bot = i_rd_data = row k+1 mod H.
  - Each cycle: o_wr_en=1, o_wr_addr=k, o_wr_data = next-state(top, mid, bot).
  - If k ≤ H-2: o_rd_en=1, o_rd_addr=(k+2) mod H. No read at k=H-1.
  - End of each cycle: top ← mid, mid ← i_rd_data, k ← k+1.
  - k=H-1 → DONE.
- Toroidal wrap:
  - Vertical wrap comes from the read order: H-1 before 0, and 0 re-read after H-1.
  - Horizontal wrap: column 0 neighbours column W-1, in the row evaluator.
- Per-cell rule: survive on 2 or 3 live neighbours, birth on exactly 3. Implemented by one next-cell-state instance per column, 8 neighbours each.
- Neighbour bit order for column c: {top[c-1], top[c], top[c+1], mid[c-1], mid[c+1], bot[c-1], bot[c], bot[c+1]}, indices mod FIELD_W. Order does not affect the result.
- DONE: o_done=1. At end of cycle: o_bank ← ~o_bank, o_gen_cnt ← o_gen_cnt+1, state → IDLE.
- Read and write addresses never alias: they always target opposite banks. The source bank is never written during a generation.

## Timing
- Reset: state=IDLE, o_bank=0, o_gen_cnt=0, o_busy=0, o_done=0, o_rd_en=0, o_wr_en=0, o_rd_addr=0, o_wr_addr=0, o_wr_data=0, window regs=0.
- Let cycle 0 be the cycle in which i_start is sampled high in IDLE:
  - PRIME occupies cycles 1–3.
  - RUN occupies cycles 4 to H+3; row k is written in cycle k+4.
  - DONE is cycle H+4.
  - The new o_bank and o_gen_cnt are visible from cycle H+5.
- Generation latency is H+4 cycles. Back-to-back: i_start held high re-enters PRIME at cycle H+6.
- i_start high in DONE is ignored. It is sampled again in IDLE at cycle H+5.
- Reset mid-operation (any state): immediate return to reset values next cycle.
  - o_bank reverts to 0. The partially written destination bank is garbage.
  - No o_done is emitted.
- o_wr_data is combinational from top, mid and i_rd_data. All other outputs are registered.
- All outputs are deasserted in IDLE.

## Structure
- defs package:
  - NEIGHBOURS_CNT (already present).
  - FIELD_W_DEF and FIELD_H_DEF constants.
  - gen_seq_state_t enum {IDLE, PRIME, RUN, DONE}.
- Sub-module next_row_state, parameter FIELD_W:
  - Inputs: top, mid, bot. Output: next row.
  - Instantiates FIELD_W next_cell_state instances with horizontal-wrap neighbour gathering.
- gen_sequencer holds the FSM, row counter, phase counter, window registers, bank bit and generation counter.
- Static assert: FIELD_H ≥ 3 and FIELD_W ≥ 3.

## Test plan
All scenarios use FIELD_W=8, FIELD_H=6, a behavioural 2-bank RAM with 1-cycle read latency, and a golden-model comparison of every written row.
- Blinker:
  - Stimulus: bank0 row2 = 8'b00011100; pulse i_start.
  - Response: o_done at cycle 10; bank1 rows 1/2/3 = 8'b00001000; all other rows 0; o_bank=1, o_gen_cnt=1.
  - Second generation restores the original pattern in bank0.
- Block still-life:
  - Stimulus: 2×2 block at rows 2–3, columns 3–4.
  - Response: unchanged over 5 back-to-back generations (i_start held high); o_gen_cnt=5; each o_done spaced 11 cycles apart.
- Wrap:
  - Stimulus: glider straddling row 5/row 0 and column 7/column 0.
  - Response: after 4 generations, glider shifted by (+1,+1) modulo 6×8, matching the golden model.
- Protocol check, every cycle:
  - o_rd_addr sequence per generation is 5,0,1,2,3,4,5,0.
  - o_wr_addr sequence is 0..5.
  - No o_rd_en at k=5.
  - i_start pulsed in PRIME, RUN or DONE is ignored: exactly one o_done.
- Reset mid-RUN:
  - Stimulus: assert i_rst at k=3 for one cycle.
  - Response: next cycle o_busy=0, o_bank=0, o_gen_cnt=0, no o_done; a subsequent i_start completes normally.
- Counter wrap:
  - Stimulus: GEN_CNT_W=2, run 5 generations.
  - Response: o_gen_cnt sequence 1,2,3,0,1; o_bank toggles each generation.
